// File: rtl/fft_quad_input_scheduler.sv
// fft_quad_input_scheduler: round-robin frame scheduler sharing one FFT among four sources,
// with a 4-deep tag FIFO that labels FFT output frames with their source index.
module fft_quad_input_scheduler #(
    parameter int SIZE_BUFFER   = 1,
    parameter int DATA_FFT_SIZE = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3:0]                 req,
    output logic [3:0]                 src_rd,
    input  logic [4*DATA_FFT_SIZE-1:0] src_data_i,
    input  logic [4*DATA_FFT_SIZE-1:0] src_data_q,
    output logic [3:0]                 grant,
    input  logic                       fft_ready,
    output logic                       fft_start,
    output logic [DATA_FFT_SIZE-1:0]   fft_data_i,
    output logic [DATA_FFT_SIZE-1:0]   fft_data_q,
    output logic                       fft_data_valid,
    input  logic                       fft_out_valid,
    output logic [1:0]                 out_tag,
    output logic                       out_tag_valid,
    output logic                       tag_err,
    output logic                       busy
);
    localparam int W = DATA_FFT_SIZE;
    localparam logic [SIZE_BUFFER-1:0] LAST = '1;

    typedef enum logic [1:0] {IDLE, START, STREAM, GAP} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             grant_q, grant_d;
    logic [1:0]             win_q, win_d;
    logic [1:0]             rr_q, rr_d;
    logic [1:0]             cand;
    logic [SIZE_BUFFER-1:0] scnt_q, scnt_d;
    logic [SIZE_BUFFER-1:0] ocnt_q;
    logic                   valid_q;
    logic [W-1:0]           di_q, dq_q;
    logic [1:0]             mem_q [4];
    logic [1:0]             wp_q, rp_q;
    logic [2:0]             occ_q;
    logic                   err_q;
    logic                   full, empty, push, pop;

    assign full  = occ_q == 3'd4;
    assign empty = occ_q == 3'd0;
    assign push  = state_q == START;
    assign pop   = fft_out_valid && !empty && ocnt_q == LAST;

    // lowest offset from rr_q wins; iterate downward so the nearest set bit is written last
    always_comb begin
        cand = rr_q;
        for (int i = 3; i >= 0; i--)
            if (req[rr_q + 2'(i)]) cand = rr_q + 2'(i);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        win_d   = win_q;
        rr_d    = rr_q;
        scnt_d  = scnt_q;
        case (state_q)
            IDLE: if (|req && fft_ready && !full) begin
                state_d = START;
                win_d   = cand;
                grant_d = 4'b0001 << cand;
            end
            START: begin
                state_d = STREAM;
                scnt_d  = '0;
            end
            STREAM: begin
                scnt_d  = scnt_q + 1'b1;
                state_d = scnt_q == LAST ? GAP : STREAM;
            end
            GAP: begin
                state_d = IDLE;
                grant_d = '0;
                rr_d    = win_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            win_q   <= '0;
            rr_q    <= '0;
            scnt_q  <= '0;
            ocnt_q  <= '0;
            valid_q <= 1'b0;
            di_q    <= '0;
            dq_q    <= '0;
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            win_q   <= win_d;
            rr_q    <= rr_d;
            scnt_q  <= scnt_d;
            valid_q <= |src_rd;
            di_q    <= |src_rd ? src_data_i[win_q*W +: W] : '0;
            dq_q    <= |src_rd ? src_data_q[win_q*W +: W] : '0;
            if (push) begin
                mem_q[wp_q] <= win_q;
                wp_q        <= wp_q + 2'd1;
            end
            if (pop) rp_q <= rp_q + 2'd1;
            occ_q <= occ_q + {2'b0, push} - {2'b0, pop};
            // counter wraps to zero on its own at the pop
            if (fft_out_valid && !empty) ocnt_q <= ocnt_q + 1'b1;
            if (fft_out_valid && empty) err_q <= 1'b1;
        end
    end

    assign src_rd         = state_q == STREAM ? grant_q : 4'b0;
    assign grant          = grant_q;
    assign fft_start      = state_q == START;
    assign busy           = state_q != IDLE;
    assign fft_data_valid = valid_q;
    assign fft_data_i     = di_q;
    assign fft_data_q     = dq_q;
    assign out_tag_valid  = !empty;
    assign out_tag        = empty ? 2'd0 : mem_q[rp_q];
    assign tag_err        = err_q;
endmodule

// File: tb/tb_fft_quad_input_scheduler.sv
// tb_fft_quad_input_scheduler: directed and random stimulus checked every cycle
// against a frame-position / queue reference model of the scheduler.
module tb_fft_quad_input_scheduler;
    localparam int SB   = 3;
    localparam int NFFT = 1 << SB;
    localparam int W    = 16;

    logic           clk = 0;
    logic           reset = 1;
    logic [3:0]     req = 0;
    logic [3:0]     src_rd;
    logic [4*W-1:0] src_data_i = 0, src_data_q = 0;
    logic [3:0]     grant;
    logic           fft_ready = 0;
    logic           fft_start;
    logic [W-1:0]   fft_data_i, fft_data_q;
    logic           fft_data_valid;
    logic           fft_out_valid = 0;
    logic [1:0]     out_tag;
    logic           out_tag_valid;
    logic           tag_err;
    logic           busy;

    fft_quad_input_scheduler #(.SIZE_BUFFER(SB), .DATA_FFT_SIZE(W)) dut (
        .clk(clk), .reset(reset), .req(req), .src_rd(src_rd),
        .src_data_i(src_data_i), .src_data_q(src_data_q), .grant(grant),
        .fft_ready(fft_ready), .fft_start(fft_start),
        .fft_data_i(fft_data_i), .fft_data_q(fft_data_q), .fft_data_valid(fft_data_valid),
        .fft_out_valid(fft_out_valid), .out_tag(out_tag), .out_tag_valid(out_tag_valid),
        .tag_err(tag_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    // model: pos = -1 idle, 0 start, 1..NFFT streaming, NFFT+1 gap
    int pos = -1, rr = 0, win = 0, oc = 0;
    int tq[$];
    bit e_err = 0, e_val = 0;
    logic [W-1:0] e_di = 0, e_dq = 0;
    bit rec = 0;
    int st_cyc[$], st_src[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        int sz0;
        bit rd, found;
        if (reset) begin
            pos = -1; rr = 0; win = 0; oc = 0; tq.delete();
            e_err = 0; e_val = 0; e_di = 0; e_dq = 0;
            return;
        end
        sz0 = tq.size();
        rd = pos >= 1 && pos <= NFFT;
        e_val = rd;
        e_di = rd ? src_data_i[win*W +: W] : '0;
        e_dq = rd ? src_data_q[win*W +: W] : '0;
        if (fft_out_valid) begin
            if (sz0 == 0) e_err = 1;
            else begin
                oc++;
                if (oc == NFFT) begin oc = 0; void'(tq.pop_front()); end
            end
        end
        if (pos == 0) tq.push_back(win);
        if (pos == -1) begin
            if (req != 0 && fft_ready && sz0 < 4) begin
                found = 0;
                for (int k = 0; k < 4; k++)
                    if (!found && req[(rr + k) % 4]) begin win = (rr + k) % 4; found = 1; end
                pos = 0;
            end
        end else if (pos == NFFT + 1) begin
            pos = -1; rr = (win + 1) % 4;
        end else pos++;
    endtask

    task automatic check_all();
        logic [3:0] oh;
        oh = 4'(1 << win);
        chk("grant", 32'(grant), 32'(pos >= 0 ? oh : 4'b0));
        chk("fft_start", 32'(fft_start), 32'(pos == 0));
        chk("src_rd", 32'(src_rd), 32'((pos >= 1 && pos <= NFFT) ? oh : 4'b0));
        chk("busy", 32'(busy), 32'(pos >= 0));
        chk("valid", 32'(fft_data_valid), 32'(e_val));
        chk("data_i", 32'(fft_data_i), 32'(e_di));
        chk("data_q", 32'(fft_data_q), 32'(e_dq));
        chk("tag_valid", 32'(out_tag_valid), 32'(tq.size() > 0));
        chk("out_tag", 32'(out_tag), 32'(tq.size() > 0 ? tq[0] : 0));
        chk("tag_err", 32'(tag_err), 32'(e_err));
        if (rec && fft_start) begin
            st_cyc.push_back(cyc);
            for (int k = 0; k < 4; k++) if (grant[k]) st_src.push_back(k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
        src_data_i = {$urandom, $urandom};
        src_data_q = {$urandom, $urandom};
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1; req = 0; fft_out_valid = 0;
        ticks(2);
        reset = 0;
    endtask

    initial begin
        do_reset();
        fft_ready = 1;
        // single source
        req = 4'b0100; tick(); req = 0;
        chk("single_start", 32'(fft_start), 32'd1);
        chk("single_grant", 32'(grant), 32'h4);
        ticks(NFFT + 3);
        chk("single_tag", 32'(out_tag), 32'd2);
        fft_out_valid = 1; ticks(NFFT); fft_out_valid = 0;
        chk("single_pop", 32'(out_tag_valid), 32'd0);
        // round robin with continuous requests
        do_reset();
        req = 4'b1111; rec = 1;
        ticks(33);
        fft_out_valid = 1;
        ticks(17);
        rec = 0; req = 0; fft_out_valid = 0;
        chk("rr_count", 32'(st_src.size()), 32'd5);
        for (int k = 0; k < st_src.size(); k++) begin
            chk("rr_order", 32'(st_src[k]), 32'(k % 4));
            if (k > 0) chk("rr_gap", 32'(st_cyc[k] - st_cyc[k-1]), 32'(NFFT + 3));
        end
        // tag tracking: sources 1, 3, 0
        do_reset();
        req = 4'b0010; tick(); req = 0; ticks(NFFT + 2);
        req = 4'b1000; tick(); req = 0; ticks(NFFT + 2);
        req = 4'b0001; tick(); req = 0; ticks(NFFT + 2);
        chk("tag0", 32'(out_tag), 32'd1);
        fft_out_valid = 1;
        ticks(NFFT); chk("tag1", 32'(out_tag), 32'd3);
        ticks(NFFT); chk("tag2", 32'(out_tag), 32'd0);
        ticks(NFFT); chk("tag_empty", 32'(out_tag_valid), 32'd0);
        fft_out_valid = 0;
        // fifo full blocks a fifth grant
        do_reset();
        req = 4'b1111;
        ticks(4 * (NFFT + 3) + 10);
        chk("full_idle", 32'(busy), 32'd0);
        chk("full_grant", 32'(grant), 32'd0);
        fft_out_valid = 1; ticks(NFFT); fft_out_valid = 0;
        tick();
        chk("full_resume", 32'(fft_start), 32'd1);
        chk("full_resume_grant", 32'(grant), 32'h1);
        req = 0;
        // error flag and reset mid-stream
        do_reset();
        fft_out_valid = 1; tick(); fft_out_valid = 0;
        chk("err_set", 32'(tag_err), 32'd1);
        req = 4'b0100; ticks(4); req = 0;
        chk("err_sticky", 32'(tag_err), 32'd1);
        chk("mid_stream", 32'(src_rd), 32'h4);
        reset = 1; tick(); reset = 0;
        chk("rst_err", 32'(tag_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", 32'(src_rd), 32'd0);
        // push and pop on the same edge
        req = 4'b0001; tick(); req = 0; ticks(NFFT + 2);
        fft_out_valid = 1; ticks(NFFT - 2);
        req = 4'b0010; tick(); req = 0;
        chk("pp_start", 32'(fft_start), 32'd1);
        chk("pp_tag_before", 32'(out_tag), 32'd0);
        tick(); fft_out_valid = 0;
        chk("pp_tag_after", 32'(out_tag), 32'd1);
        chk("pp_valid", 32'(out_tag_valid), 32'd1);
        ticks(NFFT + 2);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            req = 4'($urandom);
            fft_ready = $urandom_range(0, 3) != 0;
            fft_out_valid = $urandom_range(0, 9) < 3;
            reset = $urandom_range(0, 199) == 0;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
